// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use / control-hazard stall and flush controller for
// a 5-stage MIPS pipeline.
//
// Ports:
//   Clk, Rst            - clock (rising edge), synchronous active-low reset
//   IFID_Rs, IFID_Rt    - source register fields of the instruction in ID
//   IFID_UsesRt         - ID instruction reads rt as a source
//   IDEX_Rd             - destination register of the instruction in EX
//   IDEX_RegWrite       - EX instruction writes the register file
//   IDEX_MemRead        - EX instruction load size, nonzero means load
//   BranchTaken         - branch resolved taken this cycle
//   JumpTaken           - jump resolved this cycle
//   controlMuxSignal    - 1 passes ID control, 0 inserts a bubble (comb)
//   PCWrite             - PC load enable (comb)
//   IFIDWrite           - IF/ID load enable (comb)
//   IFIDFlush           - clear IF/ID to NOP (comb)
//   StallActive         - FSM is in STALL or FLUSH (registered)
//   BubbleCount         - saturating count of bubble cycles since reset
module hazard_stall_unit #(
   parameter int unsigned STALL_CYCLES = 1,
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [4:0]       IFID_Rs,
   input  logic [4:0]       IFID_Rt,
   input  logic             IFID_UsesRt,
   input  logic [4:0]       IDEX_Rd,
   input  logic             IDEX_RegWrite,
   input  logic [1:0]       IDEX_MemRead,
   input  logic             BranchTaken,
   input  logic             JumpTaken,
   output logic             controlMuxSignal,
   output logic             PCWrite,
   output logic             IFIDWrite,
   output logic             IFIDFlush,
   output logic             StallActive,
   output logic [CNT_W-1:0] BubbleCount
);

   localparam int unsigned REM_W = 3;
   localparam logic [REM_W-1:0] STALL_REM = REM_W'(STALL_CYCLES - 1);
   localparam logic [REM_W-1:0] FLUSH_REM = REM_W'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t           state, state_next;
   logic [REM_W-1:0] rem, rem_next;
   logic             lu, br;

   // Load-use RAW hazard against the ID sources; $zero never conflicts.
   assign lu = (IDEX_MemRead != 2'b00) & IDEX_RegWrite & (IDEX_Rd != 5'd0) &
               ((IDEX_Rd == IFID_Rs) | (IFID_UsesRt & (IDEX_Rd == IFID_Rt)));
   assign br = BranchTaken | JumpTaken;

   // State and remaining-cycle register
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state       <= RUN;
         rem         <= '0;
         StallActive <= 1'b0;
      end else begin
         state       <= state_next;
         rem         <= rem_next;
         StallActive <= (state_next != RUN);
      end
   end

   // Next state and pipeline control; a taken branch always beats a load-use
   always_comb begin
      state_next       = state;
      rem_next         = rem;
      controlMuxSignal = 1'b1;
      PCWrite          = 1'b1;
      IFIDWrite        = 1'b1;
      IFIDFlush        = 1'b0;

      if (!Rst) begin
         controlMuxSignal = 1'b0;
         PCWrite          = 1'b0;
         IFIDWrite        = 1'b0;
         IFIDFlush        = 1'b0;
         state_next       = RUN;
         rem_next         = '0;
      end else begin
         case (state)
            RUN: begin
               if (br) begin
                  controlMuxSignal = 1'b0;
                  IFIDFlush        = 1'b1;
                  if (FLUSH_CYCLES > 1) begin
                     state_next = FLUSH;
                     rem_next   = FLUSH_REM;
                  end
               end else if (lu) begin
                  controlMuxSignal = 1'b0;
                  PCWrite          = 1'b0;
                  IFIDWrite        = 1'b0;
                  if (STALL_CYCLES > 1) begin
                     state_next = STALL;
                     rem_next   = STALL_REM;
                  end
               end
            end

            STALL: begin
               controlMuxSignal = 1'b0;
               if (br) begin
                  // Branch squashes the stalled wrong-path instruction
                  IFIDFlush = 1'b1;
                  if (FLUSH_CYCLES > 1) begin
                     state_next = FLUSH;
                     rem_next   = FLUSH_REM;
                  end else begin
                     state_next = RUN;
                     rem_next   = '0;
                  end
               end else begin
                  PCWrite   = 1'b0;
                  IFIDWrite = 1'b0;
                  if (rem <= REM_W'(1)) begin
                     state_next = RUN;
                     rem_next   = '0;
                  end else begin
                     rem_next = rem - REM_W'(1);
                  end
               end
            end

            FLUSH: begin
               controlMuxSignal = 1'b0;
               IFIDFlush        = 1'b1;
               if (br) begin
                  rem_next = FLUSH_REM;
               end else if (rem <= REM_W'(1)) begin
                  state_next = RUN;
                  rem_next   = '0;
               end else begin
                  rem_next = rem - REM_W'(1);
               end
            end

            default: begin
               state_next = RUN;
               rem_next   = '0;
            end
         endcase
      end
   end

   // Saturating bubble counter
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         BubbleCount <= '0;
      end else if (!controlMuxSignal && (BubbleCount != CNT_MAX)) begin
         BubbleCount <= BubbleCount + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed bench for hazard_stall_unit using three
// configurations driven from shared inputs:
//   u_a STALL=1 FLUSH=1, u_b STALL=2 FLUSH=2, u_c STALL=3 FLUSH=3.
module tb_hazard_stall_unit;

   logic       Clk;
   logic       Rst;
   logic [4:0] rs, rt, rd;
   logic       uses_rt, reg_write, br_taken, jmp_taken;
   logic [1:0] mem_read;

   logic        a_cms, a_pcw, a_ifw, a_fl, a_sa;
   logic        b_cms, b_pcw, b_ifw, b_fl, b_sa;
   logic        c_cms, c_pcw, c_ifw, c_fl, c_sa;
   logic [15:0] a_cnt, b_cnt, c_cnt;

   int n_pass  = 0;
   int n_total = 0;

   hazard_stall_unit #(.STALL_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(16)) u_a (
      .Clk(Clk), .Rst(Rst), .IFID_Rs(rs), .IFID_Rt(rt), .IFID_UsesRt(uses_rt),
      .IDEX_Rd(rd), .IDEX_RegWrite(reg_write), .IDEX_MemRead(mem_read),
      .BranchTaken(br_taken), .JumpTaken(jmp_taken),
      .controlMuxSignal(a_cms), .PCWrite(a_pcw), .IFIDWrite(a_ifw),
      .IFIDFlush(a_fl), .StallActive(a_sa), .BubbleCount(a_cnt));

   hazard_stall_unit #(.STALL_CYCLES(2), .FLUSH_CYCLES(2), .CNT_W(16)) u_b (
      .Clk(Clk), .Rst(Rst), .IFID_Rs(rs), .IFID_Rt(rt), .IFID_UsesRt(uses_rt),
      .IDEX_Rd(rd), .IDEX_RegWrite(reg_write), .IDEX_MemRead(mem_read),
      .BranchTaken(br_taken), .JumpTaken(jmp_taken),
      .controlMuxSignal(b_cms), .PCWrite(b_pcw), .IFIDWrite(b_ifw),
      .IFIDFlush(b_fl), .StallActive(b_sa), .BubbleCount(b_cnt));

   hazard_stall_unit #(.STALL_CYCLES(3), .FLUSH_CYCLES(3), .CNT_W(16)) u_c (
      .Clk(Clk), .Rst(Rst), .IFID_Rs(rs), .IFID_Rt(rt), .IFID_UsesRt(uses_rt),
      .IDEX_Rd(rd), .IDEX_RegWrite(reg_write), .IDEX_MemRead(mem_read),
      .BranchTaken(br_taken), .JumpTaken(jmp_taken),
      .controlMuxSignal(c_cms), .PCWrite(c_pcw), .IFIDWrite(c_ifw),
      .IFIDFlush(c_fl), .StallActive(c_sa), .BubbleCount(c_cnt));

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      logic [4:0] rs;
      logic [4:0] rt;
      logic       uses_rt;
      logic [4:0] rd;
      logic       reg_write;
      logic [1:0] mem_read;
      logic       br;
      logic       jmp;
      logic       cms;
      logic       pcw;
      logic       ifw;
      logic       fl;
   } vec_t;

   localparam int unsigned NVEC = 12;
   vec_t vecs [NVEC];

   function automatic vec_t mk(input logic [4:0] i_rs, input logic [4:0] i_rt,
                               input logic i_u, input logic [4:0] i_rd,
                               input logic i_rw, input logic [1:0] i_mr,
                               input logic i_br, input logic i_jmp,
                               input logic [3:0] e);
      vec_t v;
      v.rs = i_rs; v.rt = i_rt; v.uses_rt = i_u; v.rd = i_rd;
      v.reg_write = i_rw; v.mem_read = i_mr; v.br = i_br; v.jmp = i_jmp;
      v.cms = e[3]; v.pcw = e[2]; v.ifw = e[1]; v.fl = e[0];
      return v;
   endfunction

   task automatic chk1(input string name, input logic act, input logic exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
   endtask

   task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic drive(input logic [4:0] i_rs, input logic [4:0] i_rt,
                        input logic i_u, input logic [4:0] i_rd, input logic i_rw,
                        input logic [1:0] i_mr, input logic i_br, input logic i_jmp);
      rs = i_rs; rt = i_rt; uses_rt = i_u; rd = i_rd;
      reg_write = i_rw; mem_read = i_mr; br_taken = i_br; jmp_taken = i_jmp;
   endtask

   task automatic clear_in();
      drive(5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 2'd0, 1'b0, 1'b0);
   endtask

   // Two reset cycles; returns just after release at a falling edge
   task automatic do_reset();
      Rst = 1'b0;
      clear_in();
      @(negedge Clk);
      #1;
      chk1("rst_forced_cms", a_cms, 1'b0);
      chk1("rst_forced_pcw", a_pcw, 1'b0);
      @(negedge Clk);
      Rst = 1'b1;
   endtask

   initial begin
      int exp_cnt;

      vecs[0]  = mk(5'd1,  5'd2,  1'b1, 5'd3,  1'b1, 2'd1, 1'b0, 1'b0, 4'b1110);
      vecs[1]  = mk(5'd8,  5'd2,  1'b0, 5'd8,  1'b1, 2'd3, 1'b0, 1'b0, 4'b0000);
      vecs[2]  = mk(5'd1,  5'd9,  1'b1, 5'd9,  1'b1, 2'd2, 1'b0, 1'b0, 4'b0000);
      vecs[3]  = mk(5'd1,  5'd9,  1'b0, 5'd9,  1'b1, 2'd2, 1'b0, 1'b0, 4'b1110);
      vecs[4]  = mk(5'd0,  5'd0,  1'b1, 5'd0,  1'b1, 2'd1, 1'b0, 1'b0, 4'b1110);
      vecs[5]  = mk(5'd8,  5'd2,  1'b1, 5'd8,  1'b1, 2'd0, 1'b0, 1'b0, 4'b1110);
      vecs[6]  = mk(5'd8,  5'd2,  1'b1, 5'd8,  1'b0, 2'd1, 1'b0, 1'b0, 4'b1110);
      vecs[7]  = mk(5'd8,  5'd2,  1'b1, 5'd8,  1'b1, 2'd1, 1'b1, 1'b0, 4'b0111);
      vecs[8]  = mk(5'd1,  5'd2,  1'b1, 5'd3,  1'b0, 2'd0, 1'b0, 1'b1, 4'b0111);
      vecs[9]  = mk(5'd1,  5'd2,  1'b1, 5'd3,  1'b0, 2'd0, 1'b1, 1'b0, 4'b0111);
      vecs[10] = mk(5'd31, 5'd2,  1'b0, 5'd31, 1'b1, 2'd1, 1'b0, 1'b0, 4'b0000);
      vecs[11] = mk(5'd4,  5'd5,  1'b1, 5'd6,  1'b1, 2'd1, 1'b0, 1'b0, 4'b1110);

      // Reset then release with no hazard
      do_reset();
      #1;
      chk1("rel_cms", a_cms, 1'b1);
      chk1("rel_pcw", a_pcw, 1'b1);
      chk1("rel_ifw", a_ifw, 1'b1);
      chk16("rel_cnt", a_cnt, 16'd0);
      chk1("rel_sa", a_sa, 1'b0);
      @(negedge Clk);

      // Single-cycle configuration: every vector is independent
      exp_cnt = 0;
      for (int i = 0; i < int'(NVEC); i++) begin
         drive(vecs[i].rs, vecs[i].rt, vecs[i].uses_rt, vecs[i].rd,
               vecs[i].reg_write, vecs[i].mem_read, vecs[i].br, vecs[i].jmp);
         #1;
         chk1($sformatf("v%0d_cms", i), a_cms, vecs[i].cms);
         chk1($sformatf("v%0d_pcw", i), a_pcw, vecs[i].pcw);
         chk1($sformatf("v%0d_ifw", i), a_ifw, vecs[i].ifw);
         chk1($sformatf("v%0d_fl", i),  a_fl,  vecs[i].fl);
         if (!vecs[i].cms) exp_cnt++;
         @(negedge Clk);
         chk16($sformatf("v%0d_cnt", i), a_cnt, 16'(exp_cnt));
         chk1($sformatf("v%0d_sa", i), a_sa, 1'b0);
      end

      // STALL_CYCLES=2, rt match: two stall cycles
      do_reset();
      drive(5'd3, 5'd8, 1'b1, 5'd8, 1'b1, 2'd3, 1'b0, 1'b0);
      #1;
      chk1("b_lu1_cms", b_cms, 1'b0);
      chk1("b_lu1_pcw", b_pcw, 1'b0);
      chk1("b_lu1_ifw", b_ifw, 1'b0);
      chk1("b_lu1_sa",  b_sa,  1'b0);
      @(negedge Clk);
      clear_in();
      #1;
      chk1("b_lu2_cms", b_cms, 1'b0);
      chk1("b_lu2_pcw", b_pcw, 1'b0);
      chk1("b_lu2_sa",  b_sa,  1'b1);
      @(negedge Clk);
      #1;
      chk1("b_lu3_cms", b_cms, 1'b1);
      chk1("b_lu3_sa",  b_sa,  1'b0);
      chk16("b_lu3_cnt", b_cnt, 16'd2);
      drive(5'd3, 5'd8, 1'b0, 5'd8, 1'b1, 2'd3, 1'b0, 1'b0);
      #1;
      chk1("b_nort_cms", b_cms, 1'b1);
      @(negedge Clk);

      // Branch and load-use together: flush wins, FLUSH_CYCLES=2
      do_reset();
      drive(5'd8, 5'd2, 1'b0, 5'd8, 1'b1, 2'd1, 1'b1, 1'b0);
      #1;
      chk1("b_bl1_fl",  b_fl,  1'b1);
      chk1("b_bl1_pcw", b_pcw, 1'b1);
      chk1("b_bl1_ifw", b_ifw, 1'b1);
      chk1("b_bl1_cms", b_cms, 1'b0);
      chk1("c_bl1_fl",  c_fl,  1'b1);
      @(negedge Clk);
      clear_in();
      #1;
      chk1("b_bl2_fl",  b_fl,  1'b1);
      chk1("b_bl2_cms", b_cms, 1'b0);
      chk1("b_bl2_sa",  b_sa,  1'b1);
      @(negedge Clk);
      #1;
      chk1("b_bl3_fl",  b_fl,  1'b0);
      chk1("b_bl3_cms", b_cms, 1'b1);
      chk1("b_bl3_sa",  b_sa,  1'b0);
      chk16("b_bl3_cnt", b_cnt, 16'd2);

      // Jump held into FLUSH reloads the count
      do_reset();
      drive(5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 2'd0, 1'b0, 1'b1);
      @(negedge Clk);
      #1;
      chk1("b_rl1_fl", b_fl, 1'b1);
      chk1("b_rl1_sa", b_sa, 1'b1);
      @(negedge Clk);
      clear_in();
      #1;
      chk1("b_rl2_fl", b_fl, 1'b1);
      @(negedge Clk);
      #1;
      chk1("b_rl3_cms", b_cms, 1'b1);
      chk1("b_rl3_fl",  b_fl,  1'b0);
      chk16("b_rl3_cnt", b_cnt, 16'd3);

      // STALL_CYCLES=3 full countdown
      do_reset();
      drive(5'd7, 5'd2, 1'b0, 5'd7, 1'b1, 2'd1, 1'b0, 1'b0);
      #1;
      chk1("c_st1_cms", c_cms, 1'b0);
      chk1("c_st1_ifw", c_ifw, 1'b0);
      @(negedge Clk);
      clear_in();
      #1;
      chk1("c_st2_cms", c_cms, 1'b0);
      chk1("c_st2_sa",  c_sa,  1'b1);
      @(negedge Clk);
      #1;
      chk1("c_st3_cms", c_cms, 1'b0);
      chk1("c_st3_pcw", c_pcw, 1'b0);
      chk1("c_st3_sa",  c_sa,  1'b1);
      @(negedge Clk);
      #1;
      chk1("c_st4_cms", c_cms, 1'b1);
      chk1("c_st4_sa",  c_sa,  1'b0);
      chk16("c_st4_cnt", c_cnt, 16'd3);

      // Branch aborts STALL, then reset mid-FLUSH
      do_reset();
      drive(5'd7, 5'd2, 1'b0, 5'd7, 1'b1, 2'd1, 1'b0, 1'b0);
      @(negedge Clk);
      drive(5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 2'd0, 1'b1, 1'b0);
      #1;
      chk1("c_ab1_fl",  c_fl,  1'b1);
      chk1("c_ab1_pcw", c_pcw, 1'b1);
      chk1("c_ab1_ifw", c_ifw, 1'b1);
      chk1("c_ab1_cms", c_cms, 1'b0);
      @(negedge Clk);
      clear_in();
      #1;
      chk1("c_ab2_fl",  c_fl,  1'b1);
      chk1("c_ab2_pcw", c_pcw, 1'b1);
      chk1("c_ab2_sa",  c_sa,  1'b1);
      chk16("c_ab2_cnt", c_cnt, 16'd2);
      Rst = 1'b0;
      #1;
      chk1("c_rstfl_fl", c_fl, 1'b0);
      @(negedge Clk);
      Rst = 1'b1;
      #1;
      chk1("c_postrst_cms", c_cms, 1'b1);
      chk1("c_postrst_fl",  c_fl,  1'b0);
      chk1("c_postrst_sa",  c_sa,  1'b0);
      chk16("c_postrst_cnt", c_cnt, 16'd0);

      // Reset mid-STALL
      do_reset();
      drive(5'd7, 5'd2, 1'b0, 5'd7, 1'b1, 2'd1, 1'b0, 1'b0);
      @(negedge Clk);
      clear_in();
      Rst = 1'b0;
      @(negedge Clk);
      Rst = 1'b1;
      #1;
      chk1("c_rstst_cms", c_cms, 1'b1);
      chk1("c_rstst_sa",  c_sa,  1'b0);

      // Saturation: load-use held every cycle
      do_reset();
      drive(5'd8, 5'd2, 1'b0, 5'd8, 1'b1, 2'd1, 1'b0, 1'b0);
      repeat (65534) @(negedge Clk);
      #1;
      chk16("a_sat_pre", a_cnt, 16'hFFFE);
      repeat (3) @(negedge Clk);
      #1;
      chk16("a_sat", a_cnt, 16'hFFFF);
      chk16("b_sat", b_cnt, 16'hFFFF);
      chk16("c_sat", c_cnt, 16'hFFFF);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
